// File: rtl/parity_scheduler.sv
// Round-robin arbiter feeding a shared byte-serial parity engine for four requesters.
// One word in flight: grant in IDLE, four CALC cycles (one byte each), one DONE cycle.
//   state | meaning
//   IDLE  | waiting for a request; ack is driven for the round-robin winner
//   CALC  | folding one captured byte per cycle into the accumulator
//   DONE  | result valid: done pulse, done_id and parity_out presented
module parity_scheduler #(
  parameter bit ODD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   ack,
  output logic         busy,
  output logic         done,
  output logic [1:0]   done_id,
  output logic         parity_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  cnt;
  logic [1:0]  gid;
  logic [1:0]  grant;
  logic        grant_vld;
  logic [31:0] word;
  logic        acc;
  logic        byte_par;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant_vld = 1'b1;
        grant     = ptr + 2'(i);
      end
    end
  end

  assign byte_par = ^word[{cnt, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    ack       = 4'b0000;
    case (state)
      IDLE: begin
        // Gated by reset so ack stays low while reset holds the FSM.
        if (grant_vld && reset) begin
          ack       = 4'b0001 << grant;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cnt        <= 2'd0;
      gid        <= 2'd0;
      word       <= 32'd0;
      acc        <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            word <= req_data[{grant, 5'b00000} +: 32];
            gid  <= grant;
            acc  <= 1'b0;
            cnt  <= 2'd0;
            ptr  <= grant + 2'd1;
          end
        end
        CALC: begin
          acc <= acc ^ byte_par;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) parity_out <= acc ^ byte_par ^ ODD;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign done_id = gid;

endmodule

// File: doc/parity_scheduler.md
PARITY_SCHEDULER -- requirements
Module: parity_scheduler

Interface
REQ-001 The block SHALL have parameter ODD, default 0, meaning result polarity: 0 = even parity (XOR of all bits), 1 = odd parity (inverted XOR).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request level; bit i belongs to requester i.
REQ-005 The block SHALL have port req_data, input, 128 bits: requester i word on bits [32i+31:32i].
REQ-006 The block SHALL have port ack, output, 4 bits: one-hot, one-cycle pulse marking the cycle in which requester i's word is captured.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port done_id, output, 2 bits: index of the requester whose result is presented with done.
REQ-010 The block SHALL have port parity_out, output, 1 bit: parity of the most recently completed word.

Function
REQ-011 The block SHALL share one byte-serial parity engine among four requesters; at most one word in flight.
REQ-012 The state machine SHALL have states IDLE, CALC, DONE.
- IDLE -> CALC on a clock edge with any req bit high.
- CALC -> DONE after the fourth byte.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 In IDLE with req != 0, the block SHALL grant round-robin: first set req bit at or after the priority pointer, wrapping 3 -> 0.
REQ-014 ack SHALL be combinational from state, req and pointer: ack[g] = 1 only in IDLE, only for the granted g, never more than one bit set.
REQ-015 On the edge ending an ack cycle, the block SHALL capture req_data word g and g itself, clear the accumulator and byte counter, and set the pointer to (g+1) mod 4.
REQ-016 In CALC, on byte count k = 0..3, the block SHALL XOR the reduction-XOR of captured bits [8k+7:8k] into the accumulator; the counter is 2 bits and wraps only on exit.
REQ-017 Latency SHALL be fixed: ack in cycle t, CALC in cycles t+1..t+4, done = 1 in cycle t+5, next grant possible no earlier than t+6.
REQ-018 In DONE, the block SHALL assert done = 1 and done_id = captured g.
REQ-019 parity_out SHALL equal accumulator XOR ODD, registered, updated only on entry to DONE, and held until the next completion.
REQ-020 req changes and req_data changes while busy SHALL be ignored; the captured word is immune to later input changes.
REQ-021 A requester dropping req before its ack SHALL withdraw without side effects; the pointer is unchanged if no grant occurs.
REQ-022 A requester holding req across its own done SHALL be regranted only after the other pending requesters under round-robin order.

Reset
REQ-023 While reset = 0, the block SHALL force state = IDLE, pointer = 0, counter = 0, accumulator = 0, ack = 0, busy = 0, done = 0, done_id = 0, parity_out = 0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the in-flight word with no done pulse; operation SHALL resume from IDLE on the first edge after release.

Verification
REQ-025 Single request: ODD=0, req=4'b0001, word0=32'h0000_0001 -> ack=4'b0001 at t, busy t+1..t+5, done=1, done_id=0, parity_out=1 at t+5.
REQ-026 Even data: word2=32'hFF00_00FF, req=4'b0100 -> done_id=2, parity_out=0; with ODD=1, parity_out=1.
REQ-027 Contention after reset: req=4'b1111 held continuously -> grants in order 0,1,2,3,0, ack pulses spaced 6 cycles apart.
REQ-028 Data change mid-op: word1=32'h0000_0003 captured, then word1 driven to 32'h0000_0001 during CALC -> parity_out=0.
REQ-029 Reset at t+3 of an op -> no done pulse, all outputs 0; next req=4'b1000 -> grant 3 (pointer restored to 0, only bit 3 pending).
REQ-030 Withdrawal: req=4'b0010 for one cycle while busy, deasserted before IDLE -> no ack[1] and no done_id=1 result.
